// File: rtl/rsa_keygen_core.sv
// rsa_keygen_core: derives an RSA key (N, e, d) from caller-supplied primes.
// N = p*q and phi = (p-1)*(q-1) come from a pair of shift-add multipliers
// running side by side. d = e^-1 mod phi comes from an iterative extended
// Euclid, using one restoring divider that produces one quotient bit per cycle.
//
// Handshake: start is a one-cycle request that is accepted only in IDLE or DONE.
// In those states p, q and e_in are latched and done drops on the next cycle.
// start is ignored while busy is high. busy is high from the cycle after
// acceptance until done rises. done is a level that is held until the next
// accepted start, and err, N, e and d are valid whenever done is high.
module rsa_keygen_core #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WORD_WIDTH/2-1:0] p,
  input  logic [WORD_WIDTH/2-1:0] q,
  input  logic [WORD_WIDTH-1:0]   e_in,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [WORD_WIDTH-1:0]   N,
  output logic [WORD_WIDTH-1:0]   e,
  output logic [WORD_WIDTH-1:0]   d
);

  localparam int W  = WORD_WIDTH;
  localparam int H  = WORD_WIDTH / 2;
  localparam int TW = WORD_WIDTH + 2;
  localparam int CW = $clog2(WORD_WIDTH + 1);

  localparam logic [H-1:0]         ONE_H    = H'(1);
  localparam logic [H-1:0]         TWO_H    = H'(2);
  localparam logic [W-1:0]         ONE_W    = W'(1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]        MUL_LAST = CW'(H - 1);
  localparam logic [CW-1:0]        DIV_LAST = CW'(W - 1);
  localparam logic signed [TW-1:0] T_ONE    = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK_IN,
    S_MUL,
    S_CHECK_E,
    S_DIV,
    S_UPD,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  // Latched request
  logic [H-1:0] p_r;
  logic [H-1:0] q_r;
  logic [W-1:0] e_r;

  // Twin shift-add multipliers: *_n builds p*q and *_phi builds (p-1)*(q-1)
  logic [W-1:0] mcand_n;
  logic [W-1:0] mcand_phi;
  logic [H-1:0] mplier_n;
  logic [H-1:0] mplier_phi;
  logic [W-1:0] acc_n;
  logic [W-1:0] acc_phi;

  // Shared step counter for the multiply and divide phases
  logic [CW-1:0] cnt;

  // Euclid remainders and Bezout coefficients
  logic [W-1:0]           r0;
  logic [W-1:0]           r1;
  logic signed [TW-1:0]   t0;
  logic signed [TW-1:0]   t1;

  // Restoring divider: div_q starts as the dividend and ends as the quotient
  logic [W-1:0] div_q;
  logic [W-1:0] div_rem;

  // Combinational helpers
  logic                  chk_in_bad;
  logic                  chk_e_bad;
  logic [W:0]            div_shift;
  logic [W:0]            div_diff;
  logic                  div_ge;
  logic signed [TW-1:0]  quo_s;
  logic signed [TW-1:0]  quo_t1;
  logic signed [TW-1:0]  t_new;
  logic [W-1:0]          d_fix;

  // Input checks, one divider step, the Bezout update and the final fix-up of d
  always_comb begin
    chk_in_bad = (p_r < TWO_H) || (q_r < TWO_H);
    chk_e_bad  = (e_r <= ONE_W) || (e_r >= acc_phi);
    div_shift  = {div_rem, div_q[W-1]};
    div_diff   = div_shift - {1'b0, r1};
    div_ge     = ~div_diff[W];
    quo_s      = signed'({2'b00, div_q});
    quo_t1     = quo_s * t1;
    t_new      = t0 - quo_t1;
    // A negative t0 only needs phi added, and the sum lands in [1, phi-1]
    d_fix      = t0[TW-1] ? (t0[W-1:0] + acc_phi) : t0[W-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; busy and done are decoded directly from the state
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CHECK_IN;
      end
      S_CHECK_IN: begin
        busy    = 1'b1;
        state_d = chk_in_bad ? S_DONE : S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (cnt == MUL_LAST) state_d = S_CHECK_E;
      end
      S_CHECK_E: begin
        busy    = 1'b1;
        state_d = chk_e_bad ? S_DONE : S_DIV;
      end
      S_DIV: begin
        busy = 1'b1;
        if (cnt == DIV_LAST) state_d = S_UPD;
      end
      S_UPD: begin
        busy    = 1'b1;
        state_d = (div_rem == '0) ? S_FIX : S_DIV;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_CHECK_IN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: each state advances its own slice of the computation
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r        <= '0;
      q_r        <= '0;
      e_r        <= '0;
      mcand_n    <= '0;
      mcand_phi  <= '0;
      mplier_n   <= '0;
      mplier_phi <= '0;
      acc_n      <= '0;
      acc_phi    <= '0;
      cnt        <= '0;
      r0         <= '0;
      r1         <= '0;
      t0         <= '0;
      t1         <= '0;
      div_q      <= '0;
      div_rem    <= '0;
      err        <= 1'b0;
      N          <= '0;
      e          <= '0;
      d          <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            p_r <= p;
            q_r <= q;
            e_r <= e_in;
            err <= 1'b0;
          end
        end
        S_CHECK_IN: begin
          if (chk_in_bad) begin
            // Nothing has been multiplied yet, so there is no modulus to report
            N   <= '0;
            e   <= e_r;
            d   <= '0;
            err <= 1'b1;
          end else begin
            mcand_n    <= {{H{1'b0}}, p_r};
            mcand_phi  <= {{H{1'b0}}, p_r - ONE_H};
            mplier_n   <= q_r;
            mplier_phi <= q_r - ONE_H;
            acc_n      <= '0;
            acc_phi    <= '0;
            cnt        <= '0;
          end
        end
        S_MUL: begin
          if (mplier_n[0])   acc_n   <= acc_n + mcand_n;
          if (mplier_phi[0]) acc_phi <= acc_phi + mcand_phi;
          mcand_n    <= mcand_n << 1;
          mcand_phi  <= mcand_phi << 1;
          mplier_n   <= mplier_n >> 1;
          mplier_phi <= mplier_phi >> 1;
          cnt        <= cnt + CNT_ONE;
        end
        S_CHECK_E: begin
          if (chk_e_bad) begin
            N   <= acc_n;
            e   <= e_r;
            d   <= '0;
            err <= 1'b1;
          end else begin
            r0      <= acc_phi;
            r1      <= e_r;
            t0      <= '0;
            t1      <= T_ONE;
            div_q   <= acc_phi;
            div_rem <= '0;
            cnt     <= '0;
          end
        end
        S_DIV: begin
          div_q   <= {div_q[W-2:0], div_ge};
          div_rem <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
          cnt     <= cnt + CNT_ONE;
        end
        S_UPD: begin
          r0      <= r1;
          r1      <= div_rem;
          t0      <= t1;
          t1      <= t_new;
          // The next division is old r1 divided by the remainder just found
          div_q   <= r1;
          div_rem <= '0;
          cnt     <= '0;
        end
        S_FIX: begin
          N <= acc_n;
          e <= e_r;
          if (r0 != ONE_W) begin
            d   <= '0;
            err <= 1'b1;
          end else begin
            d   <= d_fix;
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_keygen_core.sv
// tb_rsa_keygen_core: drives a 32-bit and a 16-bit instance with directed and
// random key requests and compares the results with an arithmetic model.
module tb_rsa_keygen_core;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-bit instance
  logic        start32;
  logic [15:0] p32, q32;
  logic [31:0] e_in32;
  logic        busy32, done32, err32;
  logic [31:0] n32, e32, d32;

  // 16-bit instance
  logic        start16;
  logic [7:0]  p16, q16;
  logic [15:0] e_in16;
  logic        busy16, done16, err16;
  logic [15:0] n16, e16, d16;

  rsa_keygen_core #(.WORD_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .p(p32), .q(q32), .e_in(e_in32),
    .busy(busy32), .done(done32), .err(err32), .N(n32), .e(e32), .d(d32)
  );

  rsa_keygen_core #(.WORD_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .p(p16), .q(q16), .e_in(e_in16),
    .busy(busy16), .done(done16), .err(err16), .N(n16), .e(e16), .d(d16)
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  longint prev_n[2];
  longint prev_e[2];
  longint prev_d[2];

  // Sampled DUT outputs
  logic   s_busy, s_done, s_err;
  longint s_n, s_e, s_d;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic sample(input int sel);
    if (sel != 0) begin
      s_busy = busy16; s_done = done16; s_err = err16;
      s_n = longint'(n16); s_e = longint'(e16); s_d = longint'(d16);
    end else begin
      s_busy = busy32; s_done = done32; s_err = err32;
      s_n = longint'(n32); s_e = longint'(e32); s_d = longint'(d32);
    end
  endtask

  task automatic drive(input int sel, input logic st, input longint pp, input longint qq,
                       input longint ee);
    if (sel != 0) begin
      start16 = st; p16 = 8'(pp); q16 = 8'(qq); e_in16 = 16'(ee);
    end else begin
      start32 = st; p32 = 16'(pp); q32 = 16'(qq); e_in32 = 32'(ee);
    end
  endtask

  task automatic set_start(input int sel, input logic st);
    if (sel != 0) start16 = st;
    else          start32 = st;
  endtask

  // Reference model: plain-integer key derivation plus the cycle cost of each phase
  task automatic model(input int w, input longint pp, input longint qq, input longint ee,
                       output bit m_err, output longint m_n, output longint m_d,
                       output int m_lat);
    longint phi, a, b, ta, tb, qt, tmp;
    int k;
    int h;
    h = w / 2;
    m_d = 0;
    if (pp < 2 || qq < 2) begin
      m_err = 1'b1; m_n = 0; m_lat = 1;
      return;
    end
    m_n = pp * qq;
    phi = (pp - 1) * (qq - 1);
    if (ee <= 1 || ee >= phi) begin
      m_err = 1'b1; m_lat = h + 2;
      return;
    end
    a = phi; b = ee; ta = 0; tb = 1; k = 0;
    while (b != 0) begin
      qt  = a / b;
      tmp = a % b;  a = b;   b = tmp;
      tmp = ta - qt * tb; ta = tb; tb = tmp;
      k++;
    end
    m_lat = h + 3 + k * (w + 1);
    if (a != 1) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      m_d = (ta < 0) ? ta + phi : ta;
    end
  endtask

  task automatic run_job(input int sel, input longint pp, input longint qq, input longint ee,
                         input int restart_at, input int rst_at);
    bit     m_err;
    longint m_n, m_d, ee_w;
    int     m_lat, w, lat, limit;
    bit     gap;
    w     = (sel != 0) ? 16 : 32;
    ee_w  = (sel != 0) ? (ee & 64'hFFFF) : (ee & 64'hFFFF_FFFF);
    limit = 3 + w / 2 + 48 * (w + 1) + 5;
    model(w, pp, qq, ee_w, m_err, m_n, m_d, m_lat);
    exp_q.push_back(32'(m_n));
    exp_q.push_back(32'(ee_w));
    exp_q.push_back(32'(m_d));

    @(negedge clk);
    drive(sel, 1'b1, pp, qq, ee);
    @(negedge clk);
    // Scramble the inputs: the job must run on the latched copies
    drive(sel, 1'b0, longint'($urandom), longint'($urandom), longint'($urandom));
    sample(sel);
    check_eq("busy_after_start", longint'(s_busy), 1);
    check_eq("done_cleared", longint'(s_done), 0);
    check_eq("n_held", s_n, prev_n[sel]);
    check_eq("d_held", s_d, prev_d[sel]);

    lat = 0;
    gap = 1'b0;
    while (!s_done && lat < limit) begin
      @(negedge clk);
      lat++;
      set_start(sel, 1'b0);
      if (lat == restart_at) drive(sel, 1'b1, 11, 13, 7);
      if (lat == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        sample(sel);
        rst = 1'b0;
        check_eq("rst_busy", longint'(s_busy), 0);
        check_eq("rst_done", longint'(s_done), 0);
        check_eq("rst_err", longint'(s_err), 0);
        check_eq("rst_n", s_n, 0);
        check_eq("rst_e", s_e, 0);
        check_eq("rst_d", s_d, 0);
        repeat (3) void'(exp_q.pop_front());
        for (int i = 0; i < 2; i++) begin
          prev_n[i] = 0; prev_e[i] = 0; prev_d[i] = 0;
        end
        return;
      end
      sample(sel);
      if (!s_done && !s_busy) gap = 1'b1;
    end

    if (!s_done) begin
      check_eq("done_timeout", longint'(s_done), 1);
      repeat (3) void'(exp_q.pop_front());
      return;
    end
    check_eq("latency", lat, m_lat);
    check_eq("lat_bound", longint'(lat <= 3 + w / 2 + (3 * w / 2) * (w + 1)), 1);
    check_eq("busy_gap", longint'(gap), 0);
    check_eq("busy_at_done", longint'(s_busy), 0);
    check_eq("err", longint'(s_err), longint'(m_err));
    check_eq("N", s_n, longint'(exp_q.pop_front()));
    check_eq("e", s_e, longint'(exp_q.pop_front()));
    check_eq("d", s_d, longint'(exp_q.pop_front()));
    prev_n[sel] = s_n; prev_e[sel] = s_e; prev_d[sel] = s_d;

    repeat (3) @(negedge clk);
    sample(sel);
    check_eq("done_hold", longint'(s_done), 1);
    check_eq("d_hold", s_d, m_d);
  endtask

  longint primes32[12] = '{61, 53, 251, 241, 65521, 65519, 32749, 1021, 4093, 8191, 127, 131};
  longint primes16[12] = '{251, 241, 239, 233, 229, 227, 223, 211, 199, 197, 193, 191};

  initial begin
    longint pp, qq, ee, phi;
    rst = 1'b1;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      prev_n[i] = 0; prev_e[i] = 0; prev_d[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      sample(sel);
      check_eq("reset_busy", longint'(s_busy), 0);
      check_eq("reset_done", longint'(s_done), 0);
      check_eq("reset_err", longint'(s_err), 0);
      check_eq("reset_n", s_n, 0);
      check_eq("reset_e", s_e, 0);
      check_eq("reset_d", s_d, 0);
    end
    rst = 1'b0;

    // Directed vectors
    run_job(0, 61, 53, 17, -1, -1);
    check_eq("vec_d_2753", s_d, 2753);
    run_job(0, 251, 241, 7, -1, -1);
    check_eq("vec_n_60491", s_n, 60491);
    check_eq("vec_d_17143", s_d, 17143);
    run_job(0, 11, 13, 7, -1, -1);
    check_eq("vec_d_103", s_d, 103);
    run_job(0, 61, 53, 3, -1, -1);
    check_eq("vec_gcd_err", longint'(s_err), 1);
    check_eq("vec_gcd_n", s_n, 3233);
    run_job(0, 61, 53, 3120, -1, -1);
    run_job(0, 61, 53, 1, -1, -1);
    run_job(0, 1, 53, 17, -1, -1);
    check_eq("vec_small_p_n", s_n, 0);
    run_job(0, 53, 0, 17, -1, -1);
    // Start while busy is ignored
    run_job(0, 61, 53, 17, 20, -1);
    check_eq("vec_ignored_restart_d", s_d, 2753);
    // Abort with reset, then a fresh job
    run_job(0, 61, 53, 17, -1, 40);
    run_job(0, 11, 13, 7, -1, -1);
    check_eq("vec_after_rst_d", s_d, 103);
    // Narrow instance
    run_job(1, 251, 241, 7, -1, -1);
    check_eq("vec16_d_17143", s_d, 17143);

    // Random requests on the wide instance
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) begin
        pp = longint'($urandom_range(65535, 0));
        qq = longint'($urandom_range(65535, 0));
      end else begin
        pp = primes32[$urandom_range(11, 0)];
        qq = primes32[$urandom_range(11, 0)];
      end
      phi = (pp > 0 && qq > 0) ? (pp - 1) * (qq - 1) : 0;
      if (i % 5 == 4 || phi < 4) ee = longint'($urandom);
      else ee = longint'($urandom_range(32'(phi - 1), 2));
      run_job(0, pp, qq, ee, -1, -1);
    end

    // Random requests on the narrow instance
    for (int i = 0; i < 8; i++) begin
      pp  = primes16[$urandom_range(11, 0)];
      qq  = primes16[$urandom_range(11, 0)];
      phi = (pp - 1) * (qq - 1);
      ee  = longint'($urandom_range(32'(phi - 1), 2));
      run_job(1, pp, qq, ee, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
